// File: rtl/alu_arbiter_if.sv
// Bundle of requester, shared-ALU and response signals around alu_arbiter.
// The slave modport is the arbiter's view; master is the surrounding system.
interface alu_arbiter_if;
  logic        i_req0_valid;
  logic        o_req0_ready;
  logic [3:0]  i_req0_opsel;
  logic        i_req0_is_bne;
  logic [31:0] i_req0_op1;
  logic [31:0] i_req0_op2;

  logic        i_req1_valid;
  logic        o_req1_ready;
  logic [3:0]  i_req1_opsel;
  logic        i_req1_is_bne;
  logic [31:0] i_req1_op1;
  logic [31:0] i_req1_op2;

  logic [3:0]  o_alu_opsel;
  logic        o_alu_is_bne;
  logic [31:0] o_alu_op1;
  logic [31:0] o_alu_op2;
  logic [31:0] i_alu_result;
  logic        i_alu_jump;

  logic        o_rsp_valid;
  logic        o_rsp_id;
  logic [31:0] o_rsp_result;
  logic        o_rsp_jump;
  logic        i_rsp_ready;

  logic        o_busy;

  modport slave (
    input  i_req0_valid, i_req0_opsel, i_req0_is_bne, i_req0_op1, i_req0_op2,
    input  i_req1_valid, i_req1_opsel, i_req1_is_bne, i_req1_op1, i_req1_op2,
    input  i_alu_result, i_alu_jump, i_rsp_ready,
    output o_req0_ready, o_req1_ready,
    output o_alu_opsel, o_alu_is_bne, o_alu_op1, o_alu_op2,
    output o_rsp_valid, o_rsp_id, o_rsp_result, o_rsp_jump, o_busy
  );

  modport master (
    output i_req0_valid, i_req0_opsel, i_req0_is_bne, i_req0_op1, i_req0_op2,
    output i_req1_valid, i_req1_opsel, i_req1_is_bne, i_req1_op1, i_req1_op2,
    output i_alu_result, i_alu_jump, i_rsp_ready,
    input  o_req0_ready, o_req1_ready,
    input  o_alu_opsel, o_alu_is_bne, o_alu_op1, o_alu_op2,
    input  o_rsp_valid, o_rsp_id, o_rsp_result, o_rsp_jump, o_busy
  );
endinterface

// File: rtl/alu_arbiter.sv
// Two-requester round-robin arbiter in front of one shared combinational ALU.
// One operation in flight at a time: IDLE grants, EXEC samples the ALU, RESP holds the answer.
module alu_arbiter (
  input logic          i_clk,
  input logic          i_rst,
  alu_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_e;

  state_e      state_q;
  logic        ptr_q;
  logic        id_q;
  logic        busy_q;
  logic        rspValid_q;
  logic        rspJump_q;
  logic        isBne_q;
  logic [3:0]  opsel_q;
  logic [31:0] op1_q;
  logic [31:0] op2_q;
  logic [31:0] rspResult_q;

  logic        grant0;
  logic        grant1;
  logic        accept;

  // A lone valid requester wins outright; the pointer only breaks ties.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (state_q == IDLE && !i_rst) begin
      grant0 = bus.i_req0_valid && (!bus.i_req1_valid || !ptr_q);
      grant1 = bus.i_req1_valid && (!bus.i_req0_valid || ptr_q);
    end
  end

  assign accept = grant0 | grant1;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q     <= IDLE;
      ptr_q       <= 1'b0;
      id_q        <= 1'b0;
      busy_q      <= 1'b0;
      rspValid_q  <= 1'b0;
      rspJump_q   <= 1'b0;
      isBne_q     <= 1'b0;
      opsel_q     <= 4'd0;
      op1_q       <= 32'd0;
      op2_q       <= 32'd0;
      rspResult_q <= 32'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            opsel_q <= grant1 ? bus.i_req1_opsel  : bus.i_req0_opsel;
            isBne_q <= grant1 ? bus.i_req1_is_bne : bus.i_req0_is_bne;
            op1_q   <= grant1 ? bus.i_req1_op1    : bus.i_req0_op1;
            op2_q   <= grant1 ? bus.i_req1_op2    : bus.i_req0_op2;
            id_q    <= grant1;
            ptr_q   <= grant0;
            busy_q  <= 1'b1;
            state_q <= EXEC;
          end
        end
        EXEC: begin
          rspResult_q <= bus.i_alu_result;
          rspJump_q   <= bus.i_alu_jump;
          rspValid_q  <= 1'b1;
          state_q     <= RESP;
        end
        RESP: begin
          // Returning to IDLE here means a new grant can only happen next cycle.
          if (bus.i_rsp_ready) begin
            rspValid_q <= 1'b0;
            busy_q     <= 1'b0;
            state_q    <= IDLE;
          end
        end
        default: begin
          rspValid_q <= 1'b0;
          busy_q     <= 1'b0;
          state_q    <= IDLE;
        end
      endcase
    end
  end

  assign bus.o_req0_ready  = grant0;
  assign bus.o_req1_ready  = grant1;
  assign bus.o_alu_opsel   = opsel_q;
  assign bus.o_alu_is_bne  = isBne_q;
  assign bus.o_alu_op1     = op1_q;
  assign bus.o_alu_op2     = op2_q;
  assign bus.o_rsp_valid   = rspValid_q;
  assign bus.o_rsp_id      = id_q;
  assign bus.o_rsp_result  = rspResult_q;
  assign bus.o_rsp_jump    = rspJump_q;
  assign bus.o_busy        = busy_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: expected responses go into a queue at issue time,
// and an independent monitor pops and compares them on every response handshake.
module tb_alu_arbiter;

  typedef struct packed {
    logic        id;
    logic [31:0] result;
    logic        jump;
  } rsp_t;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  int   cycleCnt;
  logic [31:0] aluNoise;
  logic        jumpNoise;
  rsp_t        expQ[$];
  int          rspCycles[$];

  alu_arbiter_if bus ();

  alu_arbiter dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cycleCnt <= cycleCnt + 1;

  // Stand-in for the shared ALU: add, sub, set-if-equal; jump when bne and operands differ.
  always_comb begin
    logic [31:0] r;
    r = 32'd0;
    case (bus.o_alu_opsel)
      4'b0000: r = bus.o_alu_op1 + bus.o_alu_op2;
      4'b0001: r = bus.o_alu_op1 - bus.o_alu_op2;
      4'b1001: r = (bus.o_alu_op1 == bus.o_alu_op2) ? 32'd1 : 32'd0;
      default: r = 32'd0;
    endcase
    bus.i_alu_result = r ^ aluNoise;
    bus.i_alu_jump   = (bus.o_alu_is_bne && (bus.o_alu_op1 != bus.o_alu_op2)) ^ jumpNoise;
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every response handshake consumes one expected entry.
  always @(negedge clk) begin
    rsp_t e;
    if (!rst && bus.o_rsp_valid === 1'b1 && bus.i_rsp_ready === 1'b1) begin
      rspCycles.push_back(cycleCnt);
      if (expQ.size() == 0) begin
        checkOutput("rsp_unexpected", 32'd1, 32'd0);
      end else begin
        e = expQ.pop_front();
        checkOutput("rsp_id", {31'd0, bus.o_rsp_id}, {31'd0, e.id});
        checkOutput("rsp_result", bus.o_rsp_result, e.result);
        checkOutput("rsp_jump", {31'd0, bus.o_rsp_jump}, {31'd0, e.jump});
      end
    end
  end

  task automatic driveReq(input int n, input logic v, input logic [3:0] opsel,
                          input logic bne, input logic [31:0] op1, input logic [31:0] op2);
    if (n == 0) begin
      bus.i_req0_valid = v; bus.i_req0_opsel = opsel; bus.i_req0_is_bne = bne;
      bus.i_req0_op1 = op1; bus.i_req0_op2 = op2;
    end else begin
      bus.i_req1_valid = v; bus.i_req1_opsel = opsel; bus.i_req1_is_bne = bne;
      bus.i_req1_op1 = op1; bus.i_req1_op2 = op2;
    end
  endtask

  // Presents one request, waits (bounded) for its grant, and returns one step past the accept edge.
  task automatic applyStimulus(input int n, input logic [3:0] opsel, input logic bne,
                               input logic [31:0] op1, input logic [31:0] op2,
                               input logic [31:0] expResult, input logic expJump,
                               input bit pushExp, output int waits);
    rsp_t e;
    logic rdy;
    driveReq(n, 1'b1, opsel, bne, op1, op2);
    waits = 0;
    rdy = 1'b0;
    while (!rdy && waits < 20) begin
      @(negedge clk);
      rdy = (n == 0) ? bus.o_req0_ready : bus.o_req1_ready;
      if (!rdy) waits++;
    end
    if (!rdy) begin
      checkOutput("grant_timeout", 32'd0, 32'd1);
    end else if (pushExp) begin
      e.id = (n == 1); e.result = expResult; e.jump = expJump;
      expQ.push_back(e);
    end
    @(posedge clk); #1;
    if (n == 0) bus.i_req0_valid = 1'b0; else bus.i_req1_valid = 1'b0;
  endtask

  task automatic waitIdle();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bus.o_busy !== 1'b0 && n < 30);
    if (n >= 30) checkOutput("idle_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int   w;
    int   n;
    bit   seen;
    rsp_t e;
    checks = 0; errors = 0; cycleCnt = 0;
    aluNoise = 32'd0; jumpNoise = 1'b0;
    bus.i_rsp_ready = 1'b1;
    driveReq(0, 1'b1, 4'd0, 1'b0, 32'd0, 32'd0);
    driveReq(1, 1'b0, 4'd0, 1'b0, 32'd0, 32'd0);
    rst = 1'b0;
    #1 rst = 1'b1;
    #1;
    checkOutput("reset_rsp_valid", {31'd0, bus.o_rsp_valid}, 32'd0);
    checkOutput("reset_busy", {31'd0, bus.o_busy}, 32'd0);
    checkOutput("reset_alu_op1", bus.o_alu_op1, 32'd0);
    checkOutput("reset_ready0", {31'd0, bus.o_req0_ready}, 32'd0);
    checkOutput("reset_rsp_result", bus.o_rsp_result, 32'd0);
    bus.i_req0_valid = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;

    // Single add from requester 0, response two cycles after accept.
    applyStimulus(0, 4'b0000, 1'b0, 32'd5, 32'd3, 32'd8, 1'b0, 1'b1, w);
    checkOutput("t1_first_cycle_grant", w, 32'd0);
    @(negedge clk);
    checkOutput("t1_exec_rsp_valid", {31'd0, bus.o_rsp_valid}, 32'd0);
    checkOutput("t1_exec_busy", {31'd0, bus.o_busy}, 32'd1);
    checkOutput("t1_alu_op1", bus.o_alu_op1, 32'd5);
    checkOutput("t1_alu_op2", bus.o_alu_op2, 32'd3);
    @(posedge clk); #1;
    @(negedge clk);
    checkOutput("t1_latency_rsp_valid", {31'd0, bus.o_rsp_valid}, 32'd1);
    waitIdle();

    // Pointer now favors 1, yet a lone req0 is granted immediately.
    applyStimulus(0, 4'b0001, 1'b0, 32'd10, 32'd4, 32'd6, 1'b0, 1'b1, w);
    checkOutput("t2_lone_req0_no_wait", w, 32'd0);
    waitIdle();

    // Both valid with pointer at 1: req1 (bne compare) first, then req0.
    driveReq(0, 1'b1, 4'b0000, 1'b0, 32'd1, 32'd1);
    bus.i_req1_valid = 1'b1;
    #1;
    checkOutput("t3_ready0_loses", {31'd0, bus.o_req0_ready}, 32'd0);
    applyStimulus(1, 4'b1001, 1'b1, 32'd7, 32'd7, 32'd1, 1'b0, 1'b1, w);
    checkOutput("t3_req1_no_wait", w, 32'd0);
    e.id = 1'b0; e.result = 32'd2; e.jump = 1'b0;
    expQ.push_back(e);
    @(negedge clk);
    checkOutput("t3_alu_is_bne", {31'd0, bus.o_alu_is_bne}, 32'd1);
    checkOutput("t3_alu_opsel", {28'd0, bus.o_alu_opsel}, 32'd9);
    checkOutput("t3_exec_ready0", {31'd0, bus.o_req0_ready}, 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    checkOutput("t3_resp_ready0", {31'd0, bus.o_req0_ready}, 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    checkOutput("t3_idle_ready0", {31'd0, bus.o_req0_ready}, 32'd1);
    @(posedge clk); #1;
    bus.i_req0_valid = 1'b0;
    waitIdle();

    // Response held under backpressure while the ALU inputs are scrambled.
    bus.i_rsp_ready = 1'b0;
    applyStimulus(1, 4'b0000, 1'b0, 32'd100, 32'd23, 32'd123, 1'b0, 1'b1, w);
    @(posedge clk); #1;
    driveReq(0, 1'b1, 4'b0000, 1'b0, 32'd20, 32'd22);
    e.id = 1'b0; e.result = 32'd42; e.jump = 1'b0;
    expQ.push_back(e);
    for (int i = 0; i < 4; i++) begin
      aluNoise = $urandom | 32'h1;
      jumpNoise = 1'b1;
      @(negedge clk);
      checkOutput("t4_hold_valid", {31'd0, bus.o_rsp_valid}, 32'd1);
      checkOutput("t4_hold_result", bus.o_rsp_result, 32'd123);
      checkOutput("t4_hold_id", {31'd0, bus.o_rsp_id}, 32'd1);
      checkOutput("t4_hold_jump", {31'd0, bus.o_rsp_jump}, 32'd0);
      checkOutput("t4_hold_ready0", {31'd0, bus.o_req0_ready}, 32'd0);
      @(posedge clk); #1;
    end
    aluNoise = 32'd0; jumpNoise = 1'b0;
    bus.i_rsp_ready = 1'b1;
    @(negedge clk);
    checkOutput("t4_no_accept_on_handshake", {31'd0, bus.o_req0_ready}, 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    checkOutput("t4_idle_rsp_valid", {31'd0, bus.o_rsp_valid}, 32'd0);
    checkOutput("t4_idle_busy", {31'd0, bus.o_busy}, 32'd0);
    checkOutput("t4_idle_ready0", {31'd0, bus.o_req0_ready}, 32'd1);
    @(posedge clk); #1;
    bus.i_req0_valid = 1'b0;
    waitIdle();

    // Reset lands in EXEC: operation dropped, no response, req0 favored afterwards.
    applyStimulus(0, 4'b0000, 1'b0, 32'h55, 32'd1, 32'h56, 1'b0, 1'b0, w);
    bus.i_req0_valid = 1'b1;
    rst = 1'b1;
    #1;
    checkOutput("t5_abort_rsp_valid", {31'd0, bus.o_rsp_valid}, 32'd0);
    checkOutput("t5_abort_busy", {31'd0, bus.o_busy}, 32'd0);
    checkOutput("t5_abort_alu_op1", bus.o_alu_op1, 32'd0);
    checkOutput("t5_abort_ready0", {31'd0, bus.o_req0_ready}, 32'd0);
    @(posedge clk); #1;

    // Both continuously valid after reset: grants 0,1,0 spaced three cycles apart.
    driveReq(0, 1'b1, 4'b0000, 1'b0, 32'd1, 32'd2);
    driveReq(1, 1'b1, 4'b0001, 1'b0, 32'd9, 32'd4);
    rst = 1'b0;
    rspCycles.delete();
    for (int g = 0; g < 3; g++) begin
      seen = 1'b0;
      n = 0;
      while (!seen && n < 10) begin
        @(negedge clk);
        if (bus.o_req0_ready || bus.o_req1_ready) seen = 1'b1;
        else n++;
      end
      if (!seen) begin
        checkOutput("t6_grant_timeout", 32'd0, 32'd1);
      end else begin
        if (g == 0) checkOutput("t6_first_idle_accepts", n, 32'd0);
        checkOutput("t6_grant_ready0", {31'd0, bus.o_req0_ready}, (g == 1) ? 32'd0 : 32'd1);
        checkOutput("t6_grant_ready1", {31'd0, bus.o_req1_ready}, (g == 1) ? 32'd1 : 32'd0);
        e.id = (g == 1); e.result = (g == 1) ? 32'd5 : 32'd3; e.jump = 1'b0;
        expQ.push_back(e);
      end
      @(posedge clk); #1;
    end
    bus.i_req0_valid = 1'b0;
    bus.i_req1_valid = 1'b0;
    waitIdle();

    n = 0;
    while (expQ.size() != 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    checkOutput("drain_expected_queue", expQ.size(), 32'd0);
    checkOutput("t6_rsp_count", rspCycles.size(), 32'd3);
    if (rspCycles.size() == 3) begin
      checkOutput("t6_spacing_a", rspCycles[1] - rspCycles[0], 32'd3);
      checkOutput("t6_spacing_b", rspCycles[2] - rspCycles[1], 32'd3);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
